// File: rtl/pwr_btn_ctrl_if.sv
// Power-button controller signal bundle: timer ticks, raw button and
// sequencer enable in; debounced level, press events and LED drive out.
interface pwr_btn_ctrl_if;
  logic tick_1ms;
  logic tick_100ms;
  logic btn_n;
  logic enable;
  logic btn_state;
  logic short_press;
  logic long_press;
  logic led_blink;

  modport master (
    output tick_1ms, tick_100ms, btn_n, enable,
    input  btn_state, short_press, long_press, led_blink
  );

  modport slave (
    input  tick_1ms, tick_100ms, btn_n, enable,
    output btn_state, short_press, long_press, led_blink
  );
endinterface

// File: rtl/pwr_btn_ctrl.sv
// Power-button front end: synchronises and debounces the raw active-low
// button on the 1 ms tick, then classifies each debounced press as short
// or long on the 100 ms tick and emits one-cycle events to the sequencer.
// Optional macro PWR_BTN_BLINK_EN adds a press-feedback blinking LED;
// without it led_blink is tied low.
module pwr_btn_ctrl #(
  parameter int DEBOUNCE_MS      = 20,
  parameter int LONG_PRESS_100MS = 40,
  parameter int BLINK_100MS      = 5
) (
  input  logic           clock,
  input  logic           reset,
  pwr_btn_ctrl_if.slave  bus
);

  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 ||
      LONG_PRESS_100MS < 1 || LONG_PRESS_100MS > 255 ||
      BLINK_100MS < 1 || BLINK_100MS > 255) begin : g_bad_param
    $error("pwr_btn_ctrl: parameters must lie in 1..255");
  end

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_MS - 1);
  localparam logic [7:0] HOLD_LAST = 8'(LONG_PRESS_100MS - 1);

  typedef enum logic [1:0] {IDLE, HELD, WAIT_REL} state_t;

  logic       sync_p0, sync_p1;
  logic       sync_p;
  logic [7:0] db_cnt;
  logic       btn_state_q;
  logic       btn_prev;
  logic       btn_rise, btn_fall;
  logic       hold_done;
  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       short_nxt, long_nxt;
  logic       short_q, long_q;

  // Two-flop synchroniser; reset to the released (high) level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= bus.btn_n;
      sync_p1 <= sync_p0;
    end
  end

  assign sync_p = ~sync_p1;

  // Debounce: a new level must survive DEBOUNCE_MS consecutive 1 ms ticks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_cnt      <= 8'd0;
      btn_state_q <= 1'b0;
    end else if (sync_p == btn_state_q) begin
      db_cnt <= 8'd0;
    end else if (bus.tick_1ms) begin
      if (db_cnt == DB_LAST) begin
        btn_state_q <= sync_p;
        db_cnt      <= 8'd0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  // Previous debounced level for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) btn_prev <= 1'b0;
    else        btn_prev <= btn_state_q;
  end

  assign btn_rise  = btn_state_q & ~btn_prev;
  assign btn_fall  = ~btn_state_q & btn_prev;
  assign hold_done = bus.tick_100ms && (hold_cnt == HOLD_LAST);

  // FSM state, hold counter and registered event pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
    end
  end

  // Next state: enable low parks the FSM in IDLE; long threshold beats release
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (!bus.enable) begin
      state_nxt = IDLE;
      hold_nxt  = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_rise) begin
            state_nxt = HELD;
            hold_nxt  = 8'd0;
          end
        end
        HELD: begin
          if (hold_done)                 state_nxt = btn_fall ? IDLE : WAIT_REL;
          else if (btn_fall)             state_nxt = IDLE;
          else if (bus.tick_100ms)       hold_nxt  = hold_cnt + 8'd1;
        end
        WAIT_REL: begin
          if (btn_fall) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Event decode, registered in the state process so pulses are one clock wide
  always_comb begin
    long_nxt  = bus.enable && (state == HELD) && hold_done;
    short_nxt = bus.enable && (state == HELD) && btn_fall && !hold_done;
  end

  assign bus.btn_state   = btn_state_q;
  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;

`ifdef PWR_BTN_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_100MS - 1);

  logic [7:0] blink_cnt;
  logic       blink_q;

  // LED: on at HELD entry, toggles every BLINK_100MS ticks in HELD, steady in WAIT_REL
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_q   <= 1'b0;
      blink_cnt <= 8'd0;
    end else begin
      case (state_nxt)
        HELD: begin
          if (state != HELD) begin
            blink_q   <= 1'b1;
            blink_cnt <= 8'd0;
          end else if (bus.tick_100ms) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_q   <= ~blink_q;
              blink_cnt <= 8'd0;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end
        end
        WAIT_REL: blink_q <= 1'b1;
        default: begin
          blink_q   <= 1'b0;
          blink_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.led_blink = blink_q;
`else
  assign bus.led_blink = 1'b0;
`endif

endmodule
